ifu_fetch: RTL and testbench

IFU_FETCH -- requirements
Module: ifu_fetch

---
 rtl/ifu_fetch.sv | 195 +++++++++++++++++++
 tb/tb_ifu_fetch.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// ifu_fetch: single-outstanding instruction fetch unit between the F-stage PC
// register and decode.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   regF_o_pc                current fetch PC from the F-stage PC register
//   ctrl_i_fetch_flush       redirect; the PC register loads its target this edge
//   ctrl_i_fetch_stall       decode is not consuming fetch outputs
//   ifu_o_stall_req          hold request to the PC register (1 = hold)
//   imem_req_*               instruction memory request (valid/ready handshake)
//   imem_rsp_*               in-order instruction response, no backpressure
//   fetch_o_*                registered instruction slot presented to decode
module ifu_fetch #(
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] regF_o_pc,
  input  logic        ctrl_i_fetch_flush,
  input  logic        ctrl_i_fetch_stall,
  output logic        ifu_o_stall_req,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        fetch_o_valid,
  output logic [31:0] fetch_o_inst,
  output logic [31:0] fetch_o_pc,
  output logic        fetch_o_misalign
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic              drop_q, drop_d;
  logic [XLEN-1:0]   buf_q, buf_d;
  logic              valid_q, valid_d;
  logic [XLEN-1:0]   inst_q, inst_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              mis_q, mis_d;

  logic              slot_free;
  logic              load_out;
  logic [XLEN-1:0]   load_inst;
  logic [XLEN-1:0]   load_pc;
  logic              load_mis;
  logic              pc_misaligned;

  // Decode can accept a new instruction if the slot is empty or being consumed.
  assign slot_free     = !valid_q || !ctrl_i_fetch_stall;
  assign pc_misaligned = (regF_o_pc[1:0] != 2'b00);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD: begin
        if (!ctrl_i_fetch_flush && !pc_misaligned) state_d = S_REQ;
      end
      S_REQ: begin
        if (imem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          if (drop_q || ctrl_i_fetch_flush || slot_free) state_d = S_LOAD;
          else                                           state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (ctrl_i_fetch_flush || !ctrl_i_fetch_stall) state_d = S_LOAD;
      end
      default: state_d = S_LOAD;
    endcase
  end

  // Output and datapath next-value logic
  always_comb begin
    addr_d          = addr_q;
    drop_d          = drop_q;
    buf_d           = buf_q;
    ifu_o_stall_req = 1'b1;
    imem_req_valid  = 1'b0;
    load_out        = 1'b0;
    load_inst       = NOP_INST;
    load_pc         = addr_q;
    load_mis        = 1'b0;

    case (state_q)
      S_LOAD: begin
        addr_d = regF_o_pc;
        // Misaligned PC never reaches memory; a NOP tagged misaligned goes to decode.
        if (!ctrl_i_fetch_flush && pc_misaligned && !ctrl_i_fetch_stall) begin
          load_out  = 1'b1;
          load_inst = NOP_INST;
          load_pc   = regF_o_pc;
          load_mis  = 1'b1;
        end
      end
      S_REQ: begin
        imem_req_valid = 1'b1;
        // The request cannot be withdrawn, so its response is marked for discard.
        if (ctrl_i_fetch_flush) drop_d = 1'b1;
      end
      S_WAIT: begin
        if (ctrl_i_fetch_flush) drop_d = 1'b1;
        if (imem_rsp_valid) begin
          if (drop_q || ctrl_i_fetch_flush) begin
            drop_d = 1'b0;
          end else if (slot_free) begin
            load_out        = 1'b1;
            load_inst       = imem_rsp_data;
            ifu_o_stall_req = 1'b0;
          end else begin
            buf_d = imem_rsp_data;
          end
        end
      end
      S_HOLD: begin
        // addr_q is frozen outside LOAD, so it still holds the buffered PC.
        if (!ctrl_i_fetch_flush && !ctrl_i_fetch_stall) begin
          load_out        = 1'b1;
          load_inst       = buf_q;
          ifu_o_stall_req = 1'b0;
        end
      end
      default: ;
    endcase

    if (ctrl_i_fetch_flush) ifu_o_stall_req = 1'b0;
    if (!rst)               ifu_o_stall_req = 1'b1;
  end

  // Decode slot next value: flush kills, new load fills, consume clears, stall holds.
  always_comb begin
    valid_d = valid_q;
    inst_d  = inst_q;
    pc_d    = pc_q;
    mis_d   = mis_q;
    if (ctrl_i_fetch_flush) begin
      valid_d = 1'b0;
    end else if (load_out) begin
      valid_d = 1'b1;
      inst_d  = load_inst;
      pc_d    = load_pc;
      mis_d   = load_mis;
    end else if (!ctrl_i_fetch_stall) begin
      valid_d = 1'b0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      drop_q  <= 1'b0;
      buf_q   <= '0;
      valid_q <= 1'b0;
      inst_q  <= NOP_INST;
      pc_q    <= '0;
      mis_q   <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      drop_q  <= drop_d;
      buf_q   <= buf_d;
      valid_q <= valid_d;
      inst_q  <= inst_d;
      pc_q    <= pc_d;
      mis_q   <= mis_d;
    end
  end

  assign imem_req_addr    = {addr_q[XLEN-1:2], 2'b00};
  assign fetch_o_valid    = valid_q;
  assign fetch_o_inst     = inst_q;
  assign fetch_o_pc       = pc_q;
  assign fetch_o_misalign = mis_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: each cycle drives inputs just after the rising
// edge and checks outputs before the following falling edge.
module tb_ifu_fetch;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk;
  logic        rst;
  logic [31:0] regF_o_pc;
  logic        ctrl_i_fetch_flush;
  logic        ctrl_i_fetch_stall;
  logic        ifu_o_stall_req;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        fetch_o_valid;
  logic [31:0] fetch_o_inst;
  logic [31:0] fetch_o_pc;
  logic        fetch_o_misalign;

  int n_assert = 0;
  int n_fail   = 0;

  ifu_fetch #(.NOP_INST(NOP)) dut (
    .clk                (clk),
    .rst                (rst),
    .regF_o_pc          (regF_o_pc),
    .ctrl_i_fetch_flush (ctrl_i_fetch_flush),
    .ctrl_i_fetch_stall (ctrl_i_fetch_stall),
    .ifu_o_stall_req    (ifu_o_stall_req),
    .imem_req_valid     (imem_req_valid),
    .imem_req_ready     (imem_req_ready),
    .imem_req_addr      (imem_req_addr),
    .imem_rsp_valid     (imem_rsp_valid),
    .imem_rsp_data      (imem_rsp_data),
    .fetch_o_valid      (fetch_o_valid),
    .fetch_o_inst       (fetch_o_inst),
    .fetch_o_pc         (fetch_o_pc),
    .fetch_o_misalign   (fetch_o_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after driving inputs.
  task automatic settle();
    #2;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] inst,
                         input logic [31:0] pc, input logic mis);
    chk({tag, "_valid"}, 32'(fetch_o_valid), 32'(v));
    chk({tag, "_inst"},  fetch_o_inst, inst);
    chk({tag, "_pc"},    fetch_o_pc, pc);
    chk({tag, "_mis"},   32'(fetch_o_misalign), 32'(mis));
  endtask

  initial begin
    rst = 1'b0; regF_o_pc = 32'h80000000; ctrl_i_fetch_flush = 1'b0;
    ctrl_i_fetch_stall = 1'b0; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    next_cycle(); next_cycle(); settle();
    chk_out("rst", 1'b0, NOP, 32'h0, 1'b0);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_stall", 32'(ifu_o_stall_req), 32'd1);

    // Basic fetch: LOAD, REQ, WAIT+rsp, output visible in cycle 4.
    next_cycle(); rst = 1'b1; settle();                       // cycle 1
    chk("c1_req_valid", 32'(imem_req_valid), 32'd0);
    chk("c1_stall", 32'(ifu_o_stall_req), 32'd1);
    next_cycle(); settle();                                   // cycle 2
    chk("c2_req_valid", 32'(imem_req_valid), 32'd1);
    chk("c2_req_addr", imem_req_addr, 32'h80000000);
    chk("c2_stall", 32'(ifu_o_stall_req), 32'd1);
    next_cycle(); imem_rsp_valid = 1'b1; imem_rsp_data = 32'h00100093; settle(); // cycle 3
    chk("c3_stall", 32'(ifu_o_stall_req), 32'd0);
    next_cycle(); imem_rsp_valid = 1'b0; regF_o_pc = 32'h80000004;
    imem_req_ready = 1'b0; settle();                          // cycle 4
    chk_out("c4", 1'b1, 32'h00100093, 32'h80000000, 1'b0);
    chk("c4_stall", 32'(ifu_o_stall_req), 32'd1);

    // Request held while memory not ready.
    for (int i = 0; i < 5; i++) begin
      next_cycle(); settle();
      chk("nr_req_valid", 32'(imem_req_valid), 32'd1);
      chk("nr_req_addr", imem_req_addr, 32'h80000004);
      chk("nr_stall", 32'(ifu_o_stall_req), 32'd1);
      if (i == 0) chk("nr_consumed", 32'(fetch_o_valid), 32'd0);
    end
    next_cycle(); imem_req_ready = 1'b1; settle();
    chk("nr_last_req", 32'(imem_req_valid), 32'd1);

    // Flush in WAIT, later response dropped, redirect PC fetched.
    next_cycle(); ctrl_i_fetch_flush = 1'b1; regF_o_pc = 32'h80000100; settle();
    chk("fw_stall", 32'(ifu_o_stall_req), 32'd0);
    next_cycle(); ctrl_i_fetch_flush = 1'b0; imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'hdeadbeef; settle();
    chk("fw_drop_stall", 32'(ifu_o_stall_req), 32'd1);
    next_cycle(); imem_rsp_valid = 1'b0; settle();
    chk("fw_valid", 32'(fetch_o_valid), 32'd0);
    chk("fw_load_req", 32'(imem_req_valid), 32'd0);
    next_cycle(); settle();
    chk("fw_req_valid", 32'(imem_req_valid), 32'd1);
    chk("fw_req_addr", imem_req_addr, 32'h80000100);

    // Decode stall with valid outputs forces HOLD.
    next_cycle(); imem_rsp_valid = 1'b1; imem_rsp_data = 32'h00200113; settle();
    chk("h_deliver_stall", 32'(ifu_o_stall_req), 32'd0);
    next_cycle(); imem_rsp_valid = 1'b0; regF_o_pc = 32'h80000104;
    ctrl_i_fetch_stall = 1'b1; settle();
    chk_out("h_first", 1'b1, 32'h00200113, 32'h80000100, 1'b0);
    next_cycle(); settle();
    chk("h_req_addr", imem_req_addr, 32'h80000104);
    chk_out("h_held_req", 1'b1, 32'h00200113, 32'h80000100, 1'b0);
    next_cycle(); imem_rsp_valid = 1'b1; imem_rsp_data = 32'h00300193; settle();
    chk("h_buffer_stall", 32'(ifu_o_stall_req), 32'd1);
    next_cycle(); imem_rsp_valid = 1'b0; settle();
    chk_out("h_hold", 1'b1, 32'h00200113, 32'h80000100, 1'b0);
    chk("h_hold_stall", 32'(ifu_o_stall_req), 32'd1);
    next_cycle(); ctrl_i_fetch_stall = 1'b0; settle();
    chk("h_drain_stall", 32'(ifu_o_stall_req), 32'd0);
    chk_out("h_drain", 1'b1, 32'h00200113, 32'h80000100, 1'b0);
    next_cycle(); regF_o_pc = 32'h80000002; settle();
    chk_out("h_out", 1'b1, 32'h00300193, 32'h80000104, 1'b0);

    // Misaligned PC: no request, NOP tagged misaligned.
    next_cycle(); settle();
    chk("m_req_valid", 32'(imem_req_valid), 32'd0);
    chk_out("m", 1'b1, NOP, 32'h80000002, 1'b1);
    chk("m_stall", 32'(ifu_o_stall_req), 32'd1);
    next_cycle(); ctrl_i_fetch_flush = 1'b1; regF_o_pc = 32'h80000200; settle();
    chk("m_req_valid2", 32'(imem_req_valid), 32'd0);
    chk("m_flush_stall", 32'(ifu_o_stall_req), 32'd0);
    next_cycle(); ctrl_i_fetch_flush = 1'b0; settle();
    chk("m_flush_valid", 32'(fetch_o_valid), 32'd0);
    chk("m_flush_req", 32'(imem_req_valid), 32'd0);
    next_cycle(); settle();
    chk("m_redir_addr", imem_req_addr, 32'h80000200);

    // Asynchronous reset while in WAIT.
    next_cycle(); settle();
    rst = 1'b0; #1;
    chk_out("ar", 1'b0, NOP, 32'h0, 1'b0);
    chk("ar_req_valid", 32'(imem_req_valid), 32'd0);
    chk("ar_stall", 32'(ifu_o_stall_req), 32'd1);
    next_cycle();
    next_cycle(); rst = 1'b1; regF_o_pc = 32'h80000300;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h00000bad; settle();
    chk("ar_r1_stall", 32'(ifu_o_stall_req), 32'd1);
    chk("ar_r1_req", 32'(imem_req_valid), 32'd0);
    next_cycle(); settle();
    chk("ar_r2_req_addr", imem_req_addr, 32'h80000300);
    chk("ar_r2_valid", 32'(fetch_o_valid), 32'd0);
    next_cycle(); imem_rsp_valid = 1'b0; settle();
    chk("ar_r3_valid", 32'(fetch_o_valid), 32'd0);
    chk("ar_r3_stall", 32'(ifu_o_stall_req), 32'd1);
    next_cycle(); imem_rsp_valid = 1'b1; imem_rsp_data = 32'h00400213; settle();
    chk("ar_r4_stall", 32'(ifu_o_stall_req), 32'd0);
    next_cycle(); imem_rsp_valid = 1'b0; regF_o_pc = 32'h80000304;
    imem_req_ready = 1'b0; settle();
    chk_out("ar_r5", 1'b1, 32'h00400213, 32'h80000300, 1'b0);

    // Flush in REQ: request still completes on old address, response dropped.
    next_cycle(); ctrl_i_fetch_flush = 1'b1; regF_o_pc = 32'h80000400; settle();
    chk("fr_req_addr", imem_req_addr, 32'h80000304);
    chk("fr_stall", 32'(ifu_o_stall_req), 32'd0);
    next_cycle(); ctrl_i_fetch_flush = 1'b0; imem_req_ready = 1'b1; settle();
    chk("fr_req_valid", 32'(imem_req_valid), 32'd1);
    chk("fr_req_addr2", imem_req_addr, 32'h80000304);
    next_cycle(); imem_rsp_valid = 1'b1; imem_rsp_data = 32'h11111111; settle();
    chk("fr_drop_stall", 32'(ifu_o_stall_req), 32'd1);
    next_cycle(); imem_rsp_valid = 1'b0; settle();
    chk("fr_valid", 32'(fetch_o_valid), 32'd0);
    next_cycle(); settle();
    chk("fr_new_addr", imem_req_addr, 32'h80000400);
    chk("fr_new_req", 32'(imem_req_valid), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
